decode_stage_hz: RTL

Parametrised decode stage with an ID/EX pipeline register, an internal register file with write-through bypass, load-use hazard detection, flush/hold control and a two-word (instruction + immediate) capture FSM. It sits between fetch and execute. It takes the raw instruction word plus the control bundle that the combinational control unit generates from that word. It drives the ID/EX register outputs and a fetch stall request.

---
 rtl/decode_stage_hz.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/decode_stage_hz.sv
// rtl/decode_stage_hz.sv - decode stage: ID/EX register, bypassed register file, load-use stall, two-word capture
module decode_stage_hz #(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16,
  parameter int PC_W    = 32,
  parameter int N_REGS  = 8,
  parameter int CTRL_W  = 32,
  parameter int RS_LSB  = 8,
  parameter int RT_LSB  = 5,
  parameter int SHAMT_W = 4,
  localparam int ADDR_W = $clog2(N_REGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [PC_W-1:0]    pc,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic               mem_read_in,
  input  logic               uses_rs,
  input  logic               uses_rt,
  input  logic               two_word,
  input  logic               flush,
  input  logic               hold,
  input  logic               wb_we,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [CTRL_W-1:0]  ctrl_r,
  output logic               valid_r,
  output logic               mem_read_r,
  output logic [DATA_W-1:0]  rs_data_r,
  output logic [DATA_W-1:0]  rt_data_r,
  output logic [DATA_W-1:0]  imm_r,
  output logic [ADDR_W-1:0]  rd_addr_r,
  output logic [ADDR_W-1:0]  rs_addr_r,
  output logic [ADDR_W-1:0]  rt_addr_r,
  output logic [SHAMT_W-1:0] shamt_r,
  output logic [PC_W-1:0]    pc_r,
  output logic               stall_if
);

  typedef enum logic {IDLE, IMM} state_t;
  state_t state;

  logic [DATA_W-1:0]  regs [N_REGS];
  logic [ADDR_W-1:0]  pend_rs, pend_rt;
  logic [SHAMT_W-1:0] pend_shamt;
  logic [PC_W-1:0]    pend_pc;
  logic [CTRL_W-1:0]  pend_ctrl;
  logic               pend_mem_read;

  logic [ADDR_W-1:0]  dec_rs, dec_rt, sel_rs, sel_rt;
  logic [SHAMT_W-1:0] dec_shamt, sel_shamt;
  logic [PC_W-1:0]    sel_pc;
  logic [CTRL_W-1:0]  sel_ctrl;
  logic               sel_mem_read;
  logic [DATA_W-1:0]  imm_ext, sel_imm, rs_val, rt_val;
  logic               in_imm, load_use, do_load, do_capture;

  assign dec_rs    = instruction[RS_LSB +: ADDR_W];
  assign dec_rt    = instruction[RT_LSB +: ADDR_W];
  assign dec_shamt = instruction[SHAMT_W-1:0];

  generate
    if (DATA_W > INSTR_W) begin : g_imm_zext
      assign imm_ext = {{(DATA_W-INSTR_W){1'b0}}, instruction};
    end else begin : g_imm_trunc
      assign imm_ext = instruction[DATA_W-1:0];
    end
  endgenerate

  // In IMM the fields come from the captured first word; the current word is the immediate.
  assign in_imm       = (state == IMM);
  assign sel_rs       = in_imm ? pend_rs       : dec_rs;
  assign sel_rt       = in_imm ? pend_rt       : dec_rt;
  assign sel_shamt    = in_imm ? pend_shamt    : dec_shamt;
  assign sel_pc       = in_imm ? pend_pc       : pc;
  assign sel_ctrl     = in_imm ? pend_ctrl     : ctrl_in;
  assign sel_mem_read = in_imm ? pend_mem_read : mem_read_in;
  assign sel_imm      = in_imm ? imm_ext       : '0;

  assign rs_val = (wb_we && wb_addr == sel_rs) ? wb_data : regs[sel_rs];
  assign rt_val = (wb_we && wb_addr == sel_rt) ? wb_data : regs[sel_rt];

  assign load_use = !in_imm && instr_valid && valid_r && mem_read_r &&
                    ((uses_rs && rd_addr_r == dec_rs) || (uses_rt && rd_addr_r == dec_rt));
  assign stall_if = !flush && (hold || load_use);

  assign do_load    = instr_valid && (in_imm || (!load_use && !two_word));
  assign do_capture = !in_imm && instr_valid && !load_use && two_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Flush shares the reset path: a bubble plus a dropped pending word is the same all-zero state.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state         <= IDLE;
      valid_r       <= 1'b0;
      ctrl_r        <= '0;
      mem_read_r    <= 1'b0;
      rs_data_r     <= '0;
      rt_data_r     <= '0;
      imm_r         <= '0;
      rd_addr_r     <= '0;
      rs_addr_r     <= '0;
      rt_addr_r     <= '0;
      shamt_r       <= '0;
      pc_r          <= '0;
      pend_rs       <= '0;
      pend_rt       <= '0;
      pend_shamt    <= '0;
      pend_pc       <= '0;
      pend_ctrl     <= '0;
      pend_mem_read <= 1'b0;
    end else if (!hold) begin
      valid_r    <= do_load;
      ctrl_r     <= do_load ? sel_ctrl : '0;
      mem_read_r <= do_load && sel_mem_read;
      rs_data_r  <= do_load ? rs_val : '0;
      rt_data_r  <= do_load ? rt_val : '0;
      imm_r      <= do_load ? sel_imm : '0;
      rd_addr_r  <= do_load ? sel_rs : '0;
      rs_addr_r  <= do_load ? sel_rs : '0;
      rt_addr_r  <= do_load ? sel_rt : '0;
      shamt_r    <= do_load ? sel_shamt : '0;
      pc_r       <= do_load ? sel_pc : '0;
      if (do_capture) begin
        state         <= IMM;
        pend_rs       <= dec_rs;
        pend_rt       <= dec_rt;
        pend_shamt    <= dec_shamt;
        pend_pc       <= pc;
        pend_ctrl     <= ctrl_in;
        pend_mem_read <= mem_read_in;
      end else if (do_load) begin
        state <= IDLE;
      end
    end
  end

endmodule
